// File: rtl/dec_pkg.sv
// Shared decimal-digit types, FSM state encoding and digit legality helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dec_pkg;

  localparam int           DIG_W   = 4;
  localparam logic [3:0]   DIG_MAX = 4'd9;

  typedef logic [DIG_W-1:0] dig_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A 4-bit code is a legal decimal digit only when it lies in 0..9.
  function automatic logic is_digit(input dig_t d);
    return (d <= DIG_MAX);
  endfunction

endpackage

// File: rtl/dec_sub_cmp.sv
// Combinational NDIG-digit decimal subtractor: diff = rem - dv, ge = (rem >= dv).
// Latency: zero cycles (pure combinational).
// Backpressure: none; result follows inputs directly.
module dec_sub_cmp
  import dec_pkg::*;
#(
  parameter int NDIG = 5
) (
  input  logic [NDIG*DIG_W-1:0] rem,
  input  logic [NDIG*DIG_W-1:0] dv,
  output logic [NDIG*DIG_W-1:0] diff,
  output logic                  ge
);

  // Ripple the borrow from digit 0 upward; a negative digit result wraps by +10.
  always_comb begin
    logic             borrow;
    logic [DIG_W:0]   t;
    borrow = 1'b0;
    t      = '0;
    diff   = '0;
    for (int i = 0; i < NDIG; i++) begin
      t = {1'b0, rem[i*DIG_W +: DIG_W]} - {1'b0, dv[i*DIG_W +: DIG_W]}
          - {{DIG_W{1'b0}}, borrow};
      if (t[DIG_W]) begin
        diff[i*DIG_W +: DIG_W] = t[DIG_W-1:0] + DIG_W'(10);
        borrow                 = 1'b1;
      end else begin
        diff[i*DIG_W +: DIG_W] = t[DIG_W-1:0];
        borrow                 = 1'b0;
      end
    end
    ge = ~borrow;
  end

endmodule

// File: rtl/dec_div.sv
// Sequential decimal long divider (restoring, one quotient digit per SHIFT/SUB pass).
// Latency: out_valid 1+2*N_DIG+sum(quotient digits) cycles after accept; 1 cycle for err.
// Backpressure: in_ready only in IDLE; results held in DONE until out_ready.
module dec_div #(
  parameter int N_DIG = 8,
  parameter int M_DIG = 4,
  parameter int DIG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_DIG*DIG_W-1:0] dividend,
  input  logic [M_DIG*DIG_W-1:0] divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_DIG*DIG_W-1:0] quotient,
  output logic [M_DIG*DIG_W-1:0] remainder,
  output logic                   err
);
  import dec_pkg::*;

  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int RW    = (M_DIG + 1) * DIG_W;

  state_t                 state_q, state_d;
  logic [N_DIG*DIG_W-1:0] dd_q, dd_d;
  logic [M_DIG*DIG_W-1:0] dv_q, dv_d;
  logic [RW-1:0]          rem_q, rem_d;
  logic [N_DIG*DIG_W-1:0] quo_q, quo_d;
  logic [M_DIG*DIG_W-1:0] remo_q, remo_d;
  logic                   err_q, err_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic                   in_ok;
  logic [RW-1:0]          sub_diff;
  logic                   sub_ge;

  // Operands are legal when every digit is 0..9 and the divisor is non-zero.
  always_comb begin
    in_ok = (divisor != '0);
    for (int i = 0; i < N_DIG; i++) begin
      if (!is_digit(dividend[i*DIG_W +: DIG_W])) in_ok = 1'b0;
    end
    for (int i = 0; i < M_DIG; i++) begin
      if (!is_digit(divisor[i*DIG_W +: DIG_W])) in_ok = 1'b0;
    end
  end

  // The divisor is zero-extended by one digit to match the accumulator width.
  dec_sub_cmp #(
    .NDIG (M_DIG + 1)
  ) u_sub_cmp (
    .rem  (rem_q),
    .dv   ({{DIG_W{1'b0}}, dv_q}),
    .diff (sub_diff),
    .ge   (sub_ge)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    dd_d      = dd_q;
    dv_d      = dv_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    remo_d    = remo_q;
    err_d     = err_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          quo_d = '0;
          rem_d = '0;
          idx_d = IDX_W'(N_DIG - 1);
          if (in_ok) begin
            dd_d    = dividend;
            dv_d    = divisor;
            err_d   = 1'b0;
            state_d = SHIFT;
          end else begin
            // Illegal operands are not stored so every held digit stays 0..9.
            dd_d    = '0;
            dv_d    = '0;
            remo_d  = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        // rem < dv here, so its top digit is zero and can be shifted out.
        rem_d   = {rem_q[M_DIG*DIG_W-1:0], dd_q[idx_q*DIG_W +: DIG_W]};
        state_d = SUB;
      end
      SUB: begin
        if (sub_ge) begin
          rem_d = sub_diff;
          quo_d[idx_q*DIG_W +: DIG_W] = quo_q[idx_q*DIG_W +: DIG_W] + DIG_W'(1);
        end else if (idx_q == '0) begin
          remo_d  = rem_q[M_DIG*DIG_W-1:0];
          state_d = DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = SHIFT;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dd_q    <= '0;
      dv_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      dd_q    <= dd_d;
      dv_q    <= dv_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = remo_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dec_div.sv
// Directed bench for dec_div: BCD operand vectors with hand-computed results.
// Latency: checks out_valid rise cycle relative to the accept edge.
// Backpressure: exercises held results, reset mid-division and back-to-back traffic.
module tb_dec_div;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        err;

  int compared   = 0;
  int mismatched = 0;

  dec_div #(
    .N_DIG (8),
    .M_DIG (4),
    .DIG_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish before 300000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Present operands at a negedge; returns at the negedge after the accept edge.
  task automatic op_send(input logic [31:0] dd, input logic [15:0] dv);
    @(negedge clk);
    chk("send_in_ready", {31'd0, in_ready}, 32'd1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 32'hFFFF_FFFF;
    divisor  = 16'hFFFF;
  endtask

  // Called at the first negedge after the accept edge (cycle 1).
  task automatic op_finish(input string tag, input logic [31:0] eq, input logic [15:0] er,
                           input logic ee, input int ecyc, input int hold);
    int cyc;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 150) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_cycle"}, cyc, ecyc);
    chk({tag, "_quot"}, quotient, eq);
    chk({tag, "_rem"}, {16'd0, remainder}, {16'd0, er});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, ee});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_quot"}, quotient, eq);
      chk({tag, "_hold_rem"}, {16'd0, remainder}, {16'd0, er});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_taken_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_taken_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int  n_acc;
    int  n_res;
    logic prev_v;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset state.
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", {16'd0, remainder}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 12345678 / 1234 = 10004 r 742, S = 5.
    op_send(32'h1234_5678, 16'h1234);
    op_finish("div_a", 32'h0001_0004, 16'h0742, 1'b0, 22, 0);

    // 99999999 / 1, S = 72, with the result held for five cycles.
    op_send(32'h9999_9999, 16'h0001);
    op_finish("div_max", 32'h9999_9999, 16'h0000, 1'b0, 89, 5);

    // Zero divisor.
    op_send(32'h0000_0042, 16'h0000);
    op_finish("div_zero", 32'h0, 16'h0, 1'b1, 1, 0);

    // Non-decimal digit in the dividend.
    op_send(32'h1234_A678, 16'h0001);
    op_finish("bad_digit", 32'h0, 16'h0, 1'b1, 1, 0);

    // Legal operation after an error: quotient 0, err cleared.
    op_send(32'h0000_0005, 16'h0009);
    op_finish("small", 32'h0, 16'h0005, 1'b0, 17, 0);

    // Asynchronous reset mid-division, away from any clock edge.
    op_send(32'h9999_9999, 16'h0001);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_quot", quotient, 32'd0);
    chk("midrst_rem", {16'd0, remainder}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("midrst_quot_held", quotient, 32'd0);
    rst_n = 1'b1;

    // 100 / 7 = 14 r 2, S = 5.
    op_send(32'h0000_0100, 16'h0007);
    op_finish("after_rst", 32'h0000_0014, 16'h0002, 1'b0, 22, 0);

    // Continuous in_valid with out_ready high: one accept per result, each
    // accept one cycle after the previous DONE. Period is 18 cycles.
    dividend  = 32'h0000_0005;
    divisor   = 16'h0009;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n_acc  = 0;
    n_res  = 0;
    prev_v = 1'b0;
    for (int k = 0; k < 72; k++) begin
      if (k > 0) @(negedge clk);
      if (in_ready) n_acc++;
      if (out_valid) begin
        n_res++;
        chk("b2b_quot", quotient, 32'd0);
        chk("b2b_rem", {16'd0, remainder}, 32'h0005);
      end
      if (prev_v) chk("b2b_ready_after_done", {31'd0, in_ready}, 32'd1);
      prev_v = out_valid;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", n_acc, 32'd4);
    chk("b2b_results", n_res, 32'd4);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", {31'd0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
